// File: rtl/rr_decoder_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin decoder arbiter.
// The master side drives requests; the slave (arbiter) side drives the decoder controls.
interface rr_decoder_arbiter_if #(
    parameter int SEL_W = 3
);
    localparam int N = 1 << SEL_W;

    logic [N-1:0]     req;
    logic             done;
    logic             e;
    logic [SEL_W-1:0] sel;
    logic [N-1:0]     gnt;
    logic             busy;
    logic             timeout;

    modport master (
        output req, done,
        input  e, sel, gnt, busy, timeout
    );

    modport slave (
        input  req, done,
        output e, sel, gnt, busy, timeout
    );
endinterface

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter sharing one 3-to-8 decoder among N requesters.
// Grants are bounded to HOLD_MAX cycles and always followed by a one-cycle idle gap.
module rr_decoder_arbiter #(
    parameter int SEL_W    = 3,
    parameter int HOLD_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    rr_decoder_arbiter_if.slave  bus
);
    localparam int N     = 1 << SEL_W;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE
    } state_e;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             e_q, e_d;
    logic             timeout_q, timeout_d;

    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic [SEL_W-1:0] cand;
    logic             owner_release;
    logic             hit_limit;

    // First set request at or after ptr, wrapping modulo N.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        cand       = ptr_q;
        for (int i = 0; i < N; i++) begin
            cand = ptr_q + SEL_W'(i);
            if (!pick_found && bus.req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign owner_release = bus.done || !bus.req[sel_q];
    assign hit_limit     = (cnt_q == CNT_W'(HOLD_MAX - 1));

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        e_d       = e_q;
        timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                e_d = 1'b0;
                if (pick_found) begin
                    sel_d   = pick_idx;
                    e_d     = 1'b1;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (owner_release || hit_limit) begin
                    e_d       = 1'b0;
                    ptr_d     = sel_q + SEL_W'(1);
                    timeout_d = !owner_release;
                    state_d   = RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RELEASE: begin
                e_d     = 1'b0;
                state_d = IDLE;
            end
            default: begin
                e_d     = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            sel_q     <= '0;
            cnt_q     <= '0;
            e_q       <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            e_q       <= e_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.e       = e_q;
    assign bus.sel     = sel_q;
    assign bus.gnt     = e_q ? (N'(1) << sel_q) : '0;
    assign bus.busy    = (state_q != IDLE);
    assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Self-checking bench for rr_decoder_arbiter: vector table, hand-written corner sequences,
// and randomized traffic compared against an owner/gap reference model.
module tb_rr_decoder_arbiter;
    localparam int SEL_W    = 3;
    localparam int N        = 8;
    localparam int HOLD_MAX = 4;
    localparam int NVEC     = 21;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rr_decoder_arbiter_if #(.SEL_W(SEL_W)) bus ();

    rr_decoder_arbiter #(.SEL_W(SEL_W), .HOLD_MAX(HOLD_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       done;
        logic       e;
        logic [2:0] sel;
        logic [7:0] gnt;
        logic       busy;
        logic       to;
    } vec_t;

    vec_t vecs [NVEC];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: who owns the decoder, how long, and whether we sit in the idle gap.
    int   m_owner;
    int   m_held;
    int   m_gap;
    int   m_ptr;
    int   m_sel;
    logic m_to;

    function automatic vec_t v(input logic r, input logic [7:0] q, input logic d,
                               input logic ee, input logic [2:0] s, input logic [7:0] g,
                               input logic b, input logic t);
        vec_t x;
        x.rst = r; x.req = q; x.done = d;
        x.e = ee; x.sel = s; x.gnt = g; x.busy = b; x.to = t;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic ee, input logic [2:0] s,
                             input logic [7:0] g, input logic b, input logic t);
        check({tag, ".e"},       32'(bus.e),       32'(ee));
        check({tag, ".sel"},     32'(bus.sel),     32'(s));
        check({tag, ".gnt"},     32'(bus.gnt),     32'(g));
        check({tag, ".busy"},    32'(bus.busy),    32'(b));
        check({tag, ".timeout"}, 32'(bus.timeout), 32'(t));
    endtask

    task automatic step(input logic r, input logic [7:0] q, input logic d);
        rst      = r;
        bus.req  = q;
        bus.done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic model_edge(input logic r, input logic [7:0] q, input logic d);
        m_to = 1'b0;
        if (r) begin
            m_owner = -1; m_gap = 0; m_ptr = 0; m_sel = 0;
        end else if (m_owner >= 0) begin
            m_held++;
            if (d || !q[m_owner] || m_held == HOLD_MAX) begin
                m_to    = !d && q[m_owner];
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_gap   = 1;
            end
        end else if (m_gap != 0) begin
            m_gap = 0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && q[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_sel   = m_owner;
                    m_held  = 0;
                end
            end
        end
    endtask

    initial begin
        logic [7:0] rq;
        logic       rr;
        logic       rd;

        rst = 1'b1; bus.req = '0; bus.done = 1'b0;

        //              rst   req     done  e     sel   gnt     busy  to
        vecs[0]  = v(1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        vecs[1]  = v(1'b0, 8'h01, 1'b0, 1'b1, 3'd0, 8'h01, 1'b1, 1'b0);
        vecs[2]  = v(1'b0, 8'h01, 1'b0, 1'b1, 3'd0, 8'h01, 1'b1, 1'b0);
        vecs[3]  = v(1'b0, 8'h01, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
        vecs[4]  = v(1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        vecs[5]  = v(1'b0, 8'h04, 1'b0, 1'b1, 3'd2, 8'h04, 1'b1, 1'b0);
        vecs[6]  = v(1'b0, 8'h04, 1'b1, 1'b0, 3'd2, 8'h00, 1'b1, 1'b0);
        vecs[7]  = v(1'b0, 8'h05, 1'b0, 1'b0, 3'd2, 8'h00, 1'b0, 1'b0);
        vecs[8]  = v(1'b0, 8'h05, 1'b0, 1'b1, 3'd0, 8'h01, 1'b1, 1'b0);
        vecs[9]  = v(1'b0, 8'h05, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
        vecs[10] = v(1'b0, 8'h05, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        vecs[11] = v(1'b0, 8'h05, 1'b0, 1'b1, 3'd2, 8'h04, 1'b1, 1'b0);
        vecs[12] = v(1'b0, 8'h00, 1'b0, 1'b0, 3'd2, 8'h00, 1'b1, 1'b0);
        vecs[13] = v(1'b0, 8'h00, 1'b0, 1'b0, 3'd2, 8'h00, 1'b0, 1'b0);
        vecs[14] = v(1'b0, 8'h20, 1'b0, 1'b1, 3'd5, 8'h20, 1'b1, 1'b0);
        vecs[15] = v(1'b0, 8'h20, 1'b0, 1'b1, 3'd5, 8'h20, 1'b1, 1'b0);
        vecs[16] = v(1'b0, 8'h00, 1'b0, 1'b0, 3'd5, 8'h00, 1'b1, 1'b0);
        vecs[17] = v(1'b0, 8'h00, 1'b0, 1'b0, 3'd5, 8'h00, 1'b0, 1'b0);
        vecs[18] = v(1'b0, 8'hFF, 1'b0, 1'b1, 3'd6, 8'h40, 1'b1, 1'b0);
        vecs[19] = v(1'b0, 8'hFF, 1'b1, 1'b0, 3'd6, 8'h00, 1'b1, 1'b0);
        vecs[20] = v(1'b0, 8'h00, 1'b0, 1'b0, 3'd6, 8'h00, 1'b0, 1'b0);

        // Single requester, pointer skip/wrap, request drop.
        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].rst, vecs[i].req, vecs[i].done);
            check_out($sformatf("vec%0d", i), vecs[i].e, vecs[i].sel, vecs[i].gnt,
                      vecs[i].busy, vecs[i].to);
        end

        // Timeout: HOLD_MAX grant cycles, pulse, gap, then regrant to the same requester.
        step(1'b0, 8'h10, 1'b0);
        check_out("to_grant0", 1'b1, 3'd4, 8'h10, 1'b1, 1'b0);
        for (int k = 1; k < HOLD_MAX; k++) begin
            step(1'b0, 8'h10, 1'b0);
            check_out($sformatf("to_grant%0d", k), 1'b1, 3'd4, 8'h10, 1'b1, 1'b0);
        end
        step(1'b0, 8'h10, 1'b0);
        check_out("to_release", 1'b0, 3'd4, 8'h00, 1'b1, 1'b1);
        step(1'b0, 8'h10, 1'b0);
        check_out("to_idle", 1'b0, 3'd4, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h10, 1'b0);
        check_out("to_regrant", 1'b1, 3'd4, 8'h10, 1'b1, 1'b0);
        step(1'b0, 8'h10, 1'b1);
        check_out("to_done", 1'b0, 3'd4, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        // Full rotation with done every grant cycle.
        step(1'b1, 8'h00, 1'b0);
        check_out("rot_reset", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i <= N; i++) begin
            step(1'b0, 8'hFF, 1'b1);
            check_out($sformatf("rot%0d_grant", i), 1'b1, 3'(i % N), 8'(1 << (i % N)), 1'b1, 1'b0);
            step(1'b0, 8'hFF, 1'b1);
            check_out($sformatf("rot%0d_rel", i), 1'b0, 3'(i % N), 8'h00, 1'b1, 1'b0);
            step(1'b0, 8'hFF, 1'b1);
            check_out($sformatf("rot%0d_idle", i), 1'b0, 3'(i % N), 8'h00, 1'b0, 1'b0);
        end

        // Reset in the middle of a grant.
        step(1'b0, 8'h80, 1'b0);
        check_out("rm_grant", 1'b1, 3'd7, 8'h80, 1'b1, 1'b0);
        step(1'b0, 8'h80, 1'b0);
        check_out("rm_hold", 1'b1, 3'd7, 8'h80, 1'b1, 1'b0);
        step(1'b1, 8'h80, 1'b0);
        check_out("rm_reset", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h80, 1'b0);
        check_out("rm_regrant", 1'b1, 3'd7, 8'h80, 1'b1, 1'b0);

        // Randomized traffic against the reference model.
        rq = 8'h00;
        step(1'b1, 8'h00, 1'b0);
        model_edge(1'b1, 8'h00, 1'b0);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 4) == 0) begin
                case ($urandom_range(0, 2))
                    0:       rq = 8'(1 << $urandom_range(0, N - 1));
                    1:       rq = 8'($urandom);
                    default: rq = 8'h00;
                endcase
            end
            rr = ($urandom_range(0, 99) == 0);
            rd = ($urandom_range(0, 3) == 0);
            step(rr, rq, rd);
            model_edge(rr, rq, rd);
            check_out($sformatf("rnd%0d", c), m_owner >= 0, 3'(m_sel),
                      (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00,
                      (m_owner >= 0) || (m_gap != 0), m_to);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rr_decoder_arbiter.md
Name: rr_decoder_arbiter

Overview:
- Round-robin arbiter that shares one 3-to-8 decoder among 8 requesters.
- Drives the decoder's enable and 3-bit select, and exposes the resulting one-hot grant.
- Sequences grant / hold / release with a timeout so no requester can monopolise the decoder.
- Sits in front of the decoder-based function blocks in the combinational-circuits area.

Parameters:
- SEL_W, 3, select width; requester count N = 2**SEL_W = 8.
- HOLD_MAX, 4, maximum number of GRANT cycles before forced release (range 1..15).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- req  in  N  request vector; bit i = requester i.
- done  in  1  current owner releases the decoder; sampled only in GRANT.
- e  out  1  decoder enable; registered.
- sel  out  SEL_W  decoder select (MSB = a, LSB = c); registered.
- gnt  out  N  one-hot grant, e ? (1 << sel) : 0; combinational decode of the registered e and sel.
- busy  out  1  high in GRANT and RELEASE.
- timeout  out  1  one-cycle pulse when a grant is force-released.

Behaviour:
- Reset (synchronous, clk edge with rst=1):
  - state = IDLE, ptr = 0, cnt = 0.
  - e = 0, sel = 0, gnt = 0, busy = 0, timeout = 0.
  - rst dominates all other inputs. Reset mid-grant clears gnt on that same edge.
- State IDLE:
  - e = 0.
  - If req != 0 at an edge: choose the first set bit searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (mod N).
  - Load sel with the chosen index, set e = 1, clear cnt, go to GRANT.
  - Latency: req seen at edge k gives gnt valid immediately after edge k.
  - If req == 0: stay in IDLE.
- State GRANT, evaluated each edge with cnt already counting cycles granted so far:
  - Release when done = 1, OR req[sel] = 0, OR cnt == HOLD_MAX-1.
  - On release: e = 0, ptr = (sel+1) mod N (wraps 7 to 0), go to RELEASE.
  - timeout is set to 1 only if the release was caused by the cnt condition alone (done = 0 and req[sel] = 1).
  - Otherwise: cnt = cnt+1 and stay in GRANT.
  - Grant length is therefore at most HOLD_MAX cycles.
- State RELEASE:
  - Exactly one cycle with e = 0 and gnt = 0 (decoder idle gap).
  - timeout returns to 0; go to IDLE.
  - New requests are not evaluated here.
- Simultaneous events:
  - done together with the timeout condition counts as a normal release; no timeout pulse.
  - A req rising during GRANT or RELEASE waits for IDLE arbitration.
- Invariants:
  - gnt is one-hot or zero; never more than one bit set.
  - gnt = 0 whenever e = 0.
  - sel holds its last value while e = 0.
- busy = (state != IDLE).

Test Plan:
1. Single requester: rst then req = 8'h01, done pulsed after 2 cycles → gnt = 8'h01, sel = 0, e = 1 one edge after req; 2-cycle grant, 1 idle cycle, ptr = 1.
2. Full rotation: req = 8'hFF, done = 1 in every GRANT cycle → sel sequence 0,1,2,…,7,0; each grant is 1 cycle, followed by 1 RELEASE and 1 IDLE cycle; no timeout.
3. Pointer skip and wrap: after a grant to 2 (ptr = 3), req = 8'h05 → next grant goes to 0 (search 3..7 then 0), then 2 after the release/idle gap.
4. Timeout: HOLD_MAX = 4, req = 8'h10 held, done = 0 → gnt = 8'h10 for exactly 4 cycles; timeout = 1 for 1 cycle; 1 RELEASE cycle, then grant to 4 again.
5. Request drop: grant to 5, deassert req[5] mid-grant → e = 0 on the next edge, timeout = 0, ptr = 6.
6. Reset mid-grant: req = 8'h80 granted, rst = 1 for 1 cycle → e = 0, gnt = 0, busy = 0 at that edge; after rst drops, the search restarts from ptr = 0 and grants 7.
